// File: rtl/clock_recovery_dpll_if.sv
// clock_recovery_dpll_if: bundles the control input, serial data input and the recovered
// clock/data/status outputs of the digital clock recovery loop.
//   master modport : drives enable and data_in, observes every recovery output
//   slave modport  : the recovery loop itself
//   enable     - loop run, low holds the loop cleared
//   data_in    - asynchronous serial data
//   rec_clk    - recovered clock (NCO MSB)
//   bit_strobe - one-cycle pulse per recovered bit boundary
//   data_out   - data sampled at bit centre, data_valid pulses when it updates
//   locked     - loop lock flag
//   phase_err  - signed NCO phase seen at the last data edge
//   freq_int   - signed loop integrator (frequency offset from nominal)
interface clock_recovery_dpll_if #(
   parameter int unsigned ACC_WIDTH  = 32,
   parameter int unsigned PHASE_BITS = 8
) ();
   logic                  enable;
   logic                  data_in;
   logic                  rec_clk;
   logic                  bit_strobe;
   logic                  data_out;
   logic                  data_valid;
   logic                  locked;
   logic [PHASE_BITS-1:0] phase_err;
   logic [ACC_WIDTH-1:0]  freq_int;

   modport master (
      output enable, data_in,
      input  rec_clk, bit_strobe, data_out, data_valid, locked, phase_err, freq_int
   );

   modport slave (
      input  enable, data_in,
      output rec_clk, bit_strobe, data_out, data_valid, locked, phase_err, freq_int
   );
endinterface

// File: rtl/clock_recovery_dpll.sv
// clock_recovery_dpll: all-digital clock/data recovery. A phase-accumulator NCO, nominally
// 128 fabric cycles per bit, is pulled onto the serial data edges by a bang-bang
// proportional-plus-integral loop.
//   refclk - fabric clock, all state on its rising edge
//   rst    - asynchronous active-low reset
//   bus    - slave side of clock_recovery_dpll_if (enable/data_in in, recovery outputs out)
module clock_recovery_dpll #(
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned FREQ_NOM    = 33554432,
   parameter int unsigned KP          = 262144,
   parameter int unsigned KI          = 64,
   parameter int unsigned FREQ_LIMIT  = 1048576,
   parameter int unsigned PHASE_BITS  = 8,
   parameter int unsigned LOCK_WINDOW = 16,
   parameter int unsigned LOCK_COUNT  = 16,
   parameter int unsigned MAX_RUN     = 32
) (
   input logic                  refclk,
   input logic                  rst,
   clock_recovery_dpll_if.slave bus
);
   localparam int unsigned W1   = ACC_WIDTH + 1;
   localparam int unsigned CntW = $clog2(LOCK_COUNT + 1);
   localparam int unsigned RunW = $clog2(MAX_RUN + 1);

   localparam logic [ACC_WIDTH:0]        FreqNom = W1'(FREQ_NOM);
   localparam logic signed [ACC_WIDTH:0] KpW     = W1'(KP);
   localparam logic signed [ACC_WIDTH:0] KiW     = W1'(KI);
   localparam logic signed [ACC_WIDTH:0] LimW    = W1'(FREQ_LIMIT);
   localparam logic signed [ACC_WIDTH:0] NegLimW = -LimW;
   localparam logic signed [PHASE_BITS-1:0] LockWin = PHASE_BITS'(LOCK_WINDOW);
   localparam logic [CntW-1:0] LockMax = CntW'(LOCK_COUNT);
   localparam logic [RunW-1:0] RunMax  = RunW'(MAX_RUN);

   logic                         s1_q, s2_q, s3_q;
   logic [ACC_WIDTH-1:0]         acc_q, acc_d;
   logic signed [ACC_WIDTH-1:0]  freq_int_q, freq_int_d;
   logic                         corr_en_q, corr_en_d, corr_neg_q, corr_neg_d;
   logic [CntW-1:0]              lock_cnt_q, lock_cnt_d;
   logic [RunW-1:0]              run_cnt_q, run_cnt_d;
   logic [PHASE_BITS-1:0]        phase_err_q, phase_err_d;
   logic                         bit_strobe_q, bit_strobe_d;
   logic                         data_out_q, data_out_d;
   logic                         data_valid_q, data_valid_d;

   logic                         data_edge, wrap, in_window;
   logic signed [PHASE_BITS-1:0] p;
   logic [ACC_WIDTH:0]           corr_ext, sum;
   logic signed [ACC_WIDTH:0]    fi_step;

   always_comb begin
      data_edge = s2_q ^ s3_q;
      p         = acc_q[ACC_WIDTH-1 -: PHASE_BITS];
      in_window = (p < LockWin) && (p > -LockWin);
      corr_ext  = '0;
      if (corr_en_q) begin
         corr_ext = corr_neg_q ? -KpW : KpW;
      end
      // One extra bit so the top bit of the sum is the wrap carry; the total step is
      // always positive, so it cannot alias a negative result.
      sum  = {1'b0, acc_q} + FreqNom + {freq_int_q[ACC_WIDTH-1], freq_int_q} + corr_ext;
      wrap = sum[ACC_WIDTH];
      // Negative phase means the NCO is late: speed up.
      fi_step = $signed({freq_int_q[ACC_WIDTH-1], freq_int_q}) +
                (p[PHASE_BITS-1] ? KiW : -KiW);

      acc_d        = '0;
      freq_int_d   = '0;
      corr_en_d    = 1'b0;
      corr_neg_d   = 1'b0;
      lock_cnt_d   = '0;
      run_cnt_d    = '0;
      phase_err_d  = '0;
      bit_strobe_d = 1'b0;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;

      if (bus.enable) begin
         acc_d        = sum[ACC_WIDTH-1:0];
         freq_int_d   = freq_int_q;
         lock_cnt_d   = lock_cnt_q;
         run_cnt_d    = run_cnt_q;
         phase_err_d  = phase_err_q;
         bit_strobe_d = wrap;
         // Rising MSB is the bit centre.
         if (!acc_q[ACC_WIDTH-1] && sum[ACC_WIDTH-1]) begin
            data_out_d   = s3_q;
            data_valid_d = 1'b1;
         end
         if (data_edge) begin
            phase_err_d = p;
            corr_en_d   = 1'b1;
            corr_neg_d  = ~p[PHASE_BITS-1];
            if (fi_step > LimW) begin
               freq_int_d = LimW[ACC_WIDTH-1:0];
            end else if (fi_step < NegLimW) begin
               freq_int_d = NegLimW[ACC_WIDTH-1:0];
            end else begin
               freq_int_d = fi_step[ACC_WIDTH-1:0];
            end
            if (!in_window) begin
               lock_cnt_d = '0;
            end else if (lock_cnt_q != LockMax) begin
               lock_cnt_d = lock_cnt_q + CntW'(1);
            end
            run_cnt_d = '0;
         end else if (wrap && (run_cnt_q != RunMax)) begin
            // Run counter parks at its limit until the next edge restarts it.
            run_cnt_d = run_cnt_q + RunW'(1);
            if (run_cnt_d == RunMax) begin
               lock_cnt_d = '0;
            end
         end
      end
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         s1_q         <= 1'b0;
         s2_q         <= 1'b0;
         s3_q         <= 1'b0;
         acc_q        <= '0;
         freq_int_q   <= '0;
         corr_en_q    <= 1'b0;
         corr_neg_q   <= 1'b0;
         lock_cnt_q   <= '0;
         run_cnt_q    <= '0;
         phase_err_q  <= '0;
         bit_strobe_q <= 1'b0;
         data_out_q   <= 1'b0;
         data_valid_q <= 1'b0;
      end else begin
         s1_q         <= bus.data_in;
         s2_q         <= s1_q;
         s3_q         <= s2_q;
         acc_q        <= acc_d;
         freq_int_q   <= freq_int_d;
         corr_en_q    <= corr_en_d;
         corr_neg_q   <= corr_neg_d;
         lock_cnt_q   <= lock_cnt_d;
         run_cnt_q    <= run_cnt_d;
         phase_err_q  <= phase_err_d;
         bit_strobe_q <= bit_strobe_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
      end
   end

   assign bus.rec_clk    = acc_q[ACC_WIDTH-1];
   assign bus.bit_strobe = bit_strobe_q;
   assign bus.data_out   = data_out_q;
   assign bus.data_valid = data_valid_q;
   assign bus.locked     = (lock_cnt_q == LockMax);
   assign bus.phase_err  = phase_err_q;
   assign bus.freq_int   = freq_int_q;
endmodule

// File: tb/tb_clock_recovery_dpll.sv
// tb_clock_recovery_dpll: randomized stimulus for clock_recovery_dpll, checked every cycle
// against a behavioural model of the loop (integer arithmetic over the loop rules), plus
// directed checks on strobe timing, lock acquisition/drop, saturation and async reset.
module tb_clock_recovery_dpll;
   localparam longint AccMod = 64'd4294967296;
   localparam longint Half   = 64'd2147483648;
   localparam longint FNom   = 33554432;
   localparam longint Kp     = 262144;
   localparam longint Ki     = 64;
   localparam longint Lim    = 1048576;

   logic refclk = 1'b0;
   logic rst;
   always #5 refclk = ~refclk;

   clock_recovery_dpll_if #(.ACC_WIDTH(32), .PHASE_BITS(8)) bus ();

   clock_recovery_dpll dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   int  n_cmp = 0;
   int  n_err = 0;

   // Model state
   longint m_acc, m_fi, m_corr;
   int     m_phase, m_lc, m_run;
   bit     m_strobe, m_dval, m_dout, m_edge;
   bit     h1, h2, h3;   // data_in as sampled 1, 2 and 3 clocks ago

   bit     din;
   int     strobes_since_edge;
   longint fi_max;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_fi = 0; m_corr = 0;
      m_phase = 0; m_lc = 0; m_run = 0;
      m_strobe = 0; m_dval = 0; m_dout = 0; m_edge = 0;
      h1 = 0; h2 = 0; h3 = 0;
   endtask

   task automatic model_step(input bit en, input bit d);
      bit     e, wrap;
      longint nacc;
      int     p;
      e      = (h2 != h3);
      m_edge = 0;
      if (!en) begin
         m_acc = 0; m_fi = 0; m_corr = 0;
         m_lc = 0; m_run = 0; m_phase = 0;
         m_strobe = 0; m_dval = 0;
      end else begin
         nacc = m_acc + FNom + m_fi + m_corr;
         wrap = (nacc >= AccMod);
         if (wrap) nacc = nacc - AccMod;
         m_dval = (m_acc < Half) && (nacc >= Half);
         if (m_dval) m_dout = h3;
         m_strobe = wrap;
         if (e) begin
            m_edge = 1;
            p = int'(m_acc >> 24);
            if (p >= 128) p = p - 256;
            m_phase = p;
            if (p >= 0) begin
               m_fi   = (m_fi - Ki < -Lim) ? -Lim : m_fi - Ki;
               m_corr = -Kp;
            end else begin
               m_fi   = (m_fi + Ki > Lim) ? Lim : m_fi + Ki;
               m_corr = Kp;
            end
            if (p < 16 && p > -16) m_lc = (m_lc < 16) ? m_lc + 1 : 16;
            else m_lc = 0;
            m_run = 0;
         end else begin
            m_corr = 0;
            if (wrap && m_run < 32) begin
               m_run++;
               if (m_run == 32) m_lc = 0;
            end
         end
         m_acc = nacc;
      end
      h3 = h2; h2 = h1; h1 = d;
   endtask

   task automatic compare_all();
      check_eq("rec_clk",    bus.rec_clk,    (m_acc >= Half) ? 1 : 0);
      check_eq("bit_strobe", bus.bit_strobe, m_strobe);
      check_eq("data_out",   bus.data_out,   m_dout);
      check_eq("data_valid", bus.data_valid, m_dval);
      check_eq("locked",     bus.locked,     (m_lc == 16) ? 1 : 0);
      check_eq("phase_err",  $signed(bus.phase_err), m_phase);
      check_eq("freq_int",   $signed(bus.freq_int),  m_fi);
   endtask

   task automatic check_all_zero(input string pfx);
      check_eq({pfx, "_rec_clk"},    bus.rec_clk,    0);
      check_eq({pfx, "_bit_strobe"}, bus.bit_strobe, 0);
      check_eq({pfx, "_data_out"},   bus.data_out,   0);
      check_eq({pfx, "_data_valid"}, bus.data_valid, 0);
      check_eq({pfx, "_locked"},     bus.locked,     0);
      check_eq({pfx, "_phase_err"},  bus.phase_err,  0);
      check_eq({pfx, "_freq_int"},   bus.freq_int,   0);
   endtask

   // One clock: drive at the falling edge, model at the rising edge, compare at the next fall.
   task automatic tick(input bit d);
      bus.data_in = d;
      @(posedge refclk);
      model_step(bus.enable, d);
      @(negedge refclk);
      compare_all();
      if (m_edge) strobes_since_edge = 0;
      else if (bus.bit_strobe) strobes_since_edge++;
      if ($signed(bus.freq_int) > fi_max) fi_max = $signed(bus.freq_int);
   endtask

   // Static data straight after (re)start: strobe cadence and duty at the nominal word.
   task automatic idle_timing(input string pfx);
      int first, second, highs, lock_seen;
      first = 0; second = 0; highs = 0; lock_seen = 0;
      for (int i = 1; i <= 300; i++) begin
         tick(din);
         if (bus.bit_strobe) begin
            if (first == 0) first = i;
            else if (second == 0) second = i;
         end
         if (i > 128 && i <= 256 && bus.rec_clk) highs++;
         if (bus.locked) lock_seen = 1;
      end
      check_eq({pfx, "_first_strobe"}, first, 128);
      check_eq({pfx, "_strobe_period"}, second - first, 128);
      check_eq({pfx, "_rec_clk_high"}, highs, 64);
      check_eq({pfx, "_never_locked"}, lock_seen, 0);
   endtask

   initial begin
      int r, sat_hits, cnt;
      longint tgt;
      rst = 1'b0;
      bus.enable  = 1'b0;
      bus.data_in = 1'b0;
      din = 0;
      strobes_since_edge = 0;
      fi_max = 0;
      model_reset();
      repeat (3) @(negedge refclk);
      check_all_zero("reset");
      rst = 1'b1;
      bus.enable = 1'b1;

      // Static input
      idle_timing("idle");

      // Alternating data at exactly 128 cycles/bit, edges placed near NCO phase 0
      r   = int'($urandom_range(0, 6));
      tgt = ((124 + r) % 128) * FNom;
      for (int i = 0; i < 200 && m_acc != tgt; i++) tick(din);
      check_eq("align_reached", m_acc, tgt);
      for (int b = 0; b < 40; b++) begin
         din = ~din;
         repeat (128) tick(din);
      end
      check_eq("align_locked", bus.locked, 1);

      // Hold data: lock must drop on the 32nd strobe without an edge
      cnt = 0;
      for (int i = 0; i < 45 * 128 && bus.locked; i++) tick(din);
      check_eq("run_drop_strobes", strobes_since_edge, 32);
      check_eq("run_drop_locked", bus.locked, 0);
      for (int i = 0; i < 300; i++) begin
         tick(din);
         if (bus.bit_strobe) cnt++;
      end
      check_eq("run_strobes_continue", (cnt >= 2) ? 1 : 0, 1);

      // Random data at 127 cycles/bit
      for (int b = 0; b < 150; b++) begin
         din = 1'($urandom_range(0, 1));
         repeat (127) tick(din);
      end

      // Disable then re-enable
      bus.enable = 1'b0;
      repeat (20) tick(din);
      check_eq("disabled_freq_int", bus.freq_int, 0);
      check_eq("disabled_locked", bus.locked, 0);
      bus.enable = 1'b1;

      // Edges only while the NCO is late: integrator must pin at +FREQ_LIMIT
      fi_max   = 0;
      sat_hits = 0;
      for (int i = 0; i < 60000 && sat_hits < 300; i++) begin
         if (m_acc >= Half) din = ~din;
         tick(din);
         if (m_fi == Lim) sat_hits++;
      end
      check_eq("sat_reached", sat_hits, 300);
      check_eq("sat_peak", fi_max, Lim);
      check_eq("sat_locked", bus.locked, 0);

      // Asynchronous reset between clock edges
      #2 rst = 1'b0;
      #1 check_all_zero("async_rst");
      model_reset();
      din = 0;
      bus.data_in = 1'b0;
      repeat (2) @(negedge refclk);
      compare_all();
      rst = 1'b1;
      idle_timing("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
